map_tile_fetch: RTL and testbench
=================================

Name: map_tile_fetch

Overview:
- Downstream consumer of the 900-entry x 8-bit tank-game map RAM (30x30 tiles).
- Converts the VGA raster position into a map RAM read address every clock and returns the tile ID for the current pixel.
- Also returns the pixel's offset inside its 16x16 tile, so the sprite stage can index tile graphics.
- Computes row addresses incrementally, so it needs no multiplier.

Parameters:
- MAP_W, 30, map width in tiles
- MAP_H, 30, map height in tiles
- TILE_SHIFT, 4, log2 of the tile size in pixels (16 px)
- X_OFFSET, 80, first screen column covered by the map; the map spans columns 80..559
- ADDR_W, 10, map RAM address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_x  in  10  current pixel column, 0..639
- pix_y  in  10  current pixel row, 0..479
- pix_valid  in  1  active-video qualifier for pix_x/pix_y
- map_address  out  ADDR_W  read address to the map RAM, registered
- map_clken  out  1  RAM clock enable
- map_readdata  in  8  map RAM data (address registered inside RAM, output unregistered)
- tile_id  out  8  tile ID for the pixel presented 3 cycles earlier
- tile_px  out  4  x offset inside the tile
- tile_py  out  4  y offset inside the tile
- tile_valid  out  1  tile_id/tile_px/tile_py are meaningful

Behaviour:
- Reset: asynchronous, active-high. While reset is asserted and after release:
  - map_address=0, tile_id=0, tile_px=0, tile_py=0, tile_valid=0
  - row_base=0, tile_row=0, prev_y=0, all pipeline valid bits 0
- map_clken is 1 whenever reset is low, and 0 during reset.
- Pipeline advances every clk with no stalls. Total latency is exactly 3 clk cycles:
  - S1 (edge 1): compute and register map_address and the side info (in_map, px, py).
  - RAM (edge 2): the RAM registers map_address; side info advances to S2.
  - S3 (edge 3): capture map_readdata into tile_id; side info appears on the outputs.
- Column: col = (pix_x - X_OFFSET) >> TILE_SHIFT, using 10-bit unsigned arithmetic. It is only used when pix_x is in range.
- Row tracking (registered, updated every cycle pix_valid=1):
  - If pix_y==0: row_base=0, tile_row=0.
  - Else if pix_y!=prev_y and pix_y[3:0]==0: tile_row+=1, and row_base+=MAP_W if tile_row<MAP_H-1. tile_row saturates at MAP_H.
  - prev_y<=pix_y.
  - S1 uses the row_base value updated for the current pix_y (compute combinationally, then register). The first pixel of a new tile row must address the new row.
- in_map = pix_valid AND X_OFFSET <= pix_x < X_OFFSET+MAP_W*16 AND tile_row < MAP_H.
- map_address = row_base + col when in_map. Otherwise it holds its previous value, so no spurious reads.
- Out-of-map results: tile_valid=0, tile_id=0, tile_px=0, tile_py=0.
- In-map results: tile_px = pix_x-X_OFFSET bits [3:0], tile_py = pix_y[3:0].
- Address range: the largest address is 899, reached at the bottom-right tile. Addresses 900..1023 are never driven.
- pix_valid=0 in mid-line: row state is not updated; the pipeline keeps flowing and emits tile_valid=0 for those slots.
- Non-monotonic pix_y (other than the jump to 0): row tracking is undefined until the next pix_y==0. Frame start always resynchronises.
- Reset asserted mid-frame: all state clears immediately. After release, the outputs are invalid until the next pix_y==0 resynchronises row tracking.

Test Plan:
- Reset, then pix_y=0, pix_x=80, pix_valid=1 for 1 cycle, with the RAM model holding mem[0]=0x05 -> map_address=0 one cycle later; tile_valid=1, tile_id=0x05, tile_px=0, tile_py=0 exactly 3 cycles after input.
- Row 0 line, pix_x sweeps 0..639 -> tile_valid=0 for x<80 and x>=560. map_address steps 0,1,..,29, each value held 16 cycles. tile_px counts 0..15 repeatedly.
- Frame raster, pix_y=16 then 17, pix_x=95 -> map_address=30 then 30, tile_py=0 then 1. pix_y=479, pix_x=559 -> map_address=899, tile_px=15, tile_py=15.
- Toggle pix_valid low for 5 cycles mid-line at pix_y=40 -> 5 consecutive tile_valid=0 slots exactly 3 cycles later. Row state is unchanged, so pix_x=80 afterwards gives map_address=60.
- Assert reset mid-line at pix_y=200 -> all outputs are 0 immediately (asynchronous). After release, pix_y=0, pix_x=100 -> map_address=1 and correct tile_id.
- Back-to-back frames (pix_y 479 -> 0) -> row_base restarts at 0 and the first pixel of the new frame addresses 0. No carry-over from tile_row saturation.

Source files
------------

// File: rtl/map_tile_fetch.sv
//----------------------------------------------------------------------------
// map_tile_fetch: turns the VGA raster position into a map RAM read address
// and returns the tile ID plus in-tile pixel offset three clocks later.
//----------------------------------------------------------------------------
`default_nettype none

module map_tile_fetch #(
  parameter int MAP_W      = 30,
  parameter int MAP_H      = 30,
  parameter int TILE_SHIFT = 4,
  parameter int X_OFFSET   = 80,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] map_address,
  output logic              map_clken,
  input  logic [7:0]        map_readdata,
  output logic [7:0]        tile_id,
  output logic [3:0]        tile_px,
  output logic [3:0]        tile_py,
  output logic              tile_valid
);

  localparam int         TR_W = $clog2(MAP_H + 1);
  localparam logic [9:0] X_LO = 10'(X_OFFSET);
  localparam logic [9:0] X_HI = 10'(X_OFFSET + (MAP_W << TILE_SHIFT));

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [TR_W-1:0]   tile_row_q, tile_row_d;
  logic [9:0]        prev_y_q, prev_y_d;
  logic              synced_q, synced_d;

  logic [ADDR_W-1:0] map_address_q;
  logic              s1_valid_q, s2_valid_q, s3_valid_q;
  logic [3:0]        s1_px_q, s1_py_q, s2_px_q, s2_py_q, s3_px_q, s3_py_q;
  logic [7:0]        tile_id_q;

  logic [9:0]        w_xrel;
  logic [9:0]        w_col;
  logic              w_in_map;

  // Row state for the current pix_y is resolved combinationally so the first
  // pixel of a new tile row already addresses that row.
  always_comb begin
    row_base_d = row_base_q;
    tile_row_d = tile_row_q;
    prev_y_d   = prev_y_q;
    synced_d   = synced_q;
    if (pix_valid) begin
      prev_y_d = pix_y;
      if (pix_y == 10'd0) begin
        row_base_d = '0;
        tile_row_d = '0;
        synced_d   = 1'b1;
      end else if ((pix_y != prev_y_q) && (pix_y[TILE_SHIFT-1:0] == '0)) begin
        if (tile_row_q < TR_W'(MAP_H))
          tile_row_d = tile_row_q + 1'b1;
        if (tile_row_q < TR_W'(MAP_H - 1))
          row_base_d = row_base_q + ADDR_W'(MAP_W);
      end
    end
  end

  assign w_xrel   = pix_x - X_LO;
  assign w_col    = w_xrel >> TILE_SHIFT;
  // Rows stay unaddressable after reset until a frame start is seen.
  assign w_in_map = pix_valid && synced_d && (pix_x >= X_LO) && (pix_x < X_HI)
                    && (tile_row_d < TR_W'(MAP_H));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_q    <= '0;
      tile_row_q    <= '0;
      prev_y_q      <= '0;
      synced_q      <= 1'b0;
      map_address_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_px_q       <= '0;
      s1_py_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_px_q       <= '0;
      s2_py_q       <= '0;
      s3_valid_q    <= 1'b0;
      s3_px_q       <= '0;
      s3_py_q       <= '0;
      tile_id_q     <= '0;
    end else begin
      row_base_q <= row_base_d;
      tile_row_q <= tile_row_d;
      prev_y_q   <= prev_y_d;
      synced_q   <= synced_d;

      if (w_in_map)
        map_address_q <= row_base_d + ADDR_W'(w_col);
      s1_valid_q <= w_in_map;
      s1_px_q    <= w_in_map ? w_xrel[3:0] : 4'd0;
      s1_py_q    <= w_in_map ? pix_y[3:0]  : 4'd0;

      s2_valid_q <= s1_valid_q;
      s2_px_q    <= s1_px_q;
      s2_py_q    <= s1_py_q;

      s3_valid_q <= s2_valid_q;
      s3_px_q    <= s2_px_q;
      s3_py_q    <= s2_py_q;
      tile_id_q  <= s2_valid_q ? map_readdata : 8'd0;
    end
  end

  assign map_address = map_address_q;
  assign map_clken   = ~reset;
  assign tile_id     = tile_id_q;
  assign tile_px     = s3_px_q;
  assign tile_py     = s3_py_q;
  assign tile_valid  = s3_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_map_tile_fetch.sv
//----------------------------------------------------------------------------
// tb_map_tile_fetch: directed raster vectors with a scoreboard queue and an
// independent monitor comparing address and tile outputs as they appear.
//----------------------------------------------------------------------------
`default_nettype none

module tb_map_tile_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid;
  logic [9:0] map_address;
  logic       map_clken;
  logic [7:0] map_readdata;
  logic [7:0] tile_id;
  logic [3:0] tile_px, tile_py;
  logic       tile_valid;

  map_tile_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_valid    (pix_valid),
    .map_address  (map_address),
    .map_clken    (map_clken),
    .map_readdata (map_readdata),
    .tile_id      (tile_id),
    .tile_px      (tile_px),
    .tile_py      (tile_py),
    .tile_valid   (tile_valid)
  );

  always #5 clk = ~clk;

  // Map RAM: address registered, data read out combinationally.
  logic [7:0] mem [0:1023];
  logic [9:0] ram_addr_q = 10'd0;
  always @(posedge clk) if (map_clken) ram_addr_q <= map_address;
  assign map_readdata = mem[ram_addr_q];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int due; int addr; } addr_exp_t;
  typedef struct { int due; bit v; int id; int px; int py; } tile_exp_t;
  addr_exp_t aq[$];
  tile_exp_t tq[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  bit m_sync = 0;
  int m_addr = 0;

  // One raster slot; hand_addr >= 0 supplies a hand-computed address.
  task automatic slot(input int x, input int y, input bit v, input int hand_addr);
    addr_exp_t ae;
    tile_exp_t te;
    bit inm;
    @(negedge clk);
    pix_x = 10'(x); pix_y = 10'(y); pix_valid = v;
    if (v && y == 0) m_sync = 1;
    inm = v && m_sync && x >= 80 && x < 560 && (y >> 4) < 30;
    if (inm) m_addr = (hand_addr >= 0) ? hand_addr : (y >> 4) * 30 + (x - 80) / 16;
    ae.due = cyc + 1; ae.addr = m_addr;
    te.due = cyc + 3; te.v = inm;
    te.id  = inm ? int'(mem[m_addr]) : 0;
    te.px  = inm ? ((x - 80) & 15) : 0;
    te.py  = inm ? (y & 15) : 0;
    aq.push_back(ae);
    tq.push_back(te);
  endtask

  always @(negedge clk) begin
    addr_exp_t ae;
    tile_exp_t te;
    if (!reset) chk("clken", int'(map_clken), 1);
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ae = aq.pop_front();
      if (ae.due < cyc) chk("addr_missed", ae.due, cyc);
      else              chk("map_address", int'(map_address), ae.addr);
    end
    while (tq.size() > 0 && tq[0].due <= cyc) begin
      te = tq.pop_front();
      if (te.due < cyc) chk("tile_missed", te.due, cyc);
      else begin
        chk("tile_valid", int'(tile_valid), int'(te.v));
        chk("tile_id",    int'(tile_id),    te.id);
        chk("tile_px",    int'(tile_px),    te.px);
        chk("tile_py",    int'(tile_py),    te.py);
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},  int'(map_address), 0);
    chk({tag, "_id"},    int'(tile_id),     0);
    chk({tag, "_px"},    int'(tile_px),     0);
    chk({tag, "_py"},    int'(tile_py),     0);
    chk({tag, "_valid"}, int'(tile_valid),  0);
    chk({tag, "_clken"}, int'(map_clken),   0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 5);
    reset = 1'b1; pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // First pixel: address 0, mem[0] = 0x05.
    slot(80, 0, 1, 0);
    // Row 0 full sweep.
    for (int x = 0; x < 640; x++) slot(x, 0, 1, -1);
    // Tile row 1 entry and the next line in the same tile row.
    slot(95, 16, 1, 30);
    slot(95, 17, 1, 30);
    slot(80, 32, 1, 60);
    // Mid-line pix_valid gap on y=40.
    for (int x = 100; x < 111; x++) slot(x, 40, !(x >= 103 && x <= 107), -1);
    slot(80, 40, 1, 60);
    // Walk down to the bottom row and the last map pixel.
    for (int y = 48; y <= 464; y += 16) slot(80, y, 1, -1);
    slot(559, 479, 1, 899);
    slot(560, 479, 1, -1);
    // Next frame restarts at 0.
    slot(80, 0, 1, 0);
    slot(559, 0, 1, 29);
    for (int y = 16; y <= 192; y += 16) slot(80, y, 1, -1);
    for (int x = 80; x < 91; x++) slot(x, 200, 1, -1);

    // Asynchronous reset mid-line.
    @(negedge clk);
    #2;
    reset = 1'b1;
    aq.delete(); tq.delete();
    m_sync = 0; m_addr = 0;
    pix_valid = 1'b0;
    #1 chk_zero_outputs("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    slot(100, 5, 1, -1);
    slot(100, 0, 1, 1);
    slot(101, 0, 1, 1);
    slot(0, 0, 0, -1);

    repeat (6) @(negedge clk);
    chk("drain_addr", aq.size(), 0);
    chk("drain_tile", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
